blk_chain_seq: RTL
==================

// Module: blk_chain_seq
// PURPOSE
//  Block-chaining sequencer between the input block stream and the AES round core.
//  Holds the IV/chaining register and issues one block at a time to the core with a start/done handshake.
//  Applies ECB/CBC/PCBC pre- and post-XORs and the chaining-register update.
//  Returns result blocks on a valid/ready stream to the output packer.
// PARAMETERS
//  BLK_S    128  block width in bits
//  IV_BITS  128  chaining register width; must equal BLK_S
// PORTS
//  clk          in   1        system clock, all logic rising-edge
//  reset        in   1        asynchronous, active-low reset
//  mode         in   2        2'b00 ECB, 2'b01 CBC, 2'b10 PCBC, 2'b11 illegal
//  encryption   in   1        encrypt request (one-hot with decryption)
//  decryption   in   1        decrypt request
//  iv_load      in   1        load iv_in into the chaining register (IDLE only)
//  iv_in        in   IV_BITS  initial vector
//  in_valid     in   1        input block valid
//  in_ready     out  1        input block accepted when in_valid & in_ready
//  in_blk       in   BLK_S    plaintext (enc) or ciphertext (dec)
//  in_last      in   1        final block of the message
//  aes_start    out  1        one-cycle pulse: core samples aes_in_blk
//  aes_in_blk   out  BLK_S    block presented to the core
//  aes_done     in   1        one-cycle pulse: aes_out_blk valid
//  aes_out_blk  in   BLK_S    core result
//  out_valid    out  1        result block valid
//  out_ready    in   1        downstream accepts the result
//  out_blk      out  BLK_S    result block
//  out_last     out  1        copy of in_last for this block
//  err          out  1        sticky: illegal mode or enc==dec at accept; cleared by reset/iv_load
// BEHAVIOUR
//  Reset values: all outputs 0; chaining reg 0; iv_valid 0; FSM IDLE.
//  FSM states and transitions:
//   IDLE   in_ready = ~iv_load & (iv_valid | mode==ECB) & ~err.
//          iv_load -> reg<=iv_in, iv_valid<=1, err<=0. iv_load wins over in_valid in the same cycle.
//          On accept: latch in_blk, in_last, mode, direction -> ISSUE.
//          Accept with illegal mode or enc==dec: set err, drop the block, stay IDLE.
//   ISSUE  aes_start=1 for exactly one cycle -> WAIT.
//   WAIT   hold until aes_done. aes_done is sampled only from the cycle after aes_start.
//          On aes_done: register out_blk, update the chain register -> OUTPUT.
//   OUTPUT out_valid=1, out_blk and out_last stable until out_ready.
//          On handshake: if out_last, iv_valid<=0; -> IDLE.
//  Pre-XOR into aes_in_blk (I = latched in_blk, C = chain register):
//   ECB: I.  CBC/PCBC encrypt: I^C.  Decrypt: I.
//  Post-XOR into out_blk (A = aes_out_blk):
//   ECB and encrypt: A.  CBC/PCBC decrypt: A^C.
//  Chain register update (C) when A is valid:
//   CBC enc: A.  CBC dec: I.  PCBC enc: I^A.  PCBC dec: I^out_blk.  ECB: unchanged.
//  Latency: in handshake -> aes_start is 1 cycle; aes_done -> out_valid is 1 cycle.
//  Throughput: one block in flight; in_ready=0 outside IDLE.
//  mode, encryption and decryption are ignored after accept until the next accept.
//  iv_load outside IDLE is ignored.
//  Reset mid-operation: immediate return to IDLE; no aes_start and no out_valid after release.
//   A late aes_done after reset is ignored.
//  Downstream stall: OUTPUT holds indefinitely; no input accepted meanwhile.
// STRUCTURE
//  Shared package (aes_defs): BLK_S, IV_BITS, MODE_ECB/MODE_CBC/MODE_PCBC encodings, FSM state encodings.
//  One combinational sub-module, chain_xor_unit.
//   Inputs: mode, direction, I, A, C.  Outputs: aes_in_blk, out_blk, C_next.
//  The FSM, registers and handshakes stay in blk_chain_seq.
// TESTING  (core stub: A = ~input, aes_done 4 cycles after aes_start)
//  1. CBC enc: iv=128'h1, P=0 -> aes_in_blk=128'h1; out_blk=~128'h1; C=~128'h1.
//  2. CBC dec: iv=128'h1, C_in=128'hF0 -> out_blk=(~128'hF0)^128'h1; chain reg=128'hF0.
//  3. PCBC enc, 2 blocks P0=0, P1=0, iv=0.
//     -> out0=all-ones; C=all-ones; aes_in_blk1=all-ones; out1=0. Last clears iv_valid.
//  4. out_ready held 0 for 10 cycles -> out_valid and out_blk stable; in_ready=0; no second aes_start.
//  5. iv_load and in_valid in the same IDLE cycle -> IV loaded; block accepted the next cycle.
//  6. Illegal inputs:
//     mode=2'b11 or enc=dec=1 at accept -> err=1, no aes_start.
//     reset low during WAIT -> all outputs 0; stub aes_done ignored.

Source files
------------

// File: rtl/aes_defs.sv
// Shared definitions for the block-chaining sequencer: widths, chaining modes, FSM states.
package aes_defs;

  localparam int BLK_S   = 128;
  localparam int IV_BITS = 128;

  typedef enum logic [1:0] {
    MODE_ECB  = 2'b00,
    MODE_CBC  = 2'b01,
    MODE_PCBC = 2'b10,
    MODE_ILL  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_WAIT   = 2'b10,
    ST_OUTPUT = 2'b11
  } state_e;

  // A request is usable only with a legal mode and exactly one direction asserted.
  function automatic logic req_legal(input logic [1:0] m, input logic enc, input logic dec);
    return (m != MODE_ILL) && (enc != dec);
  endfunction

endpackage

// File: rtl/chain_xor_unit.sv
// Combinational pre-XOR, post-XOR and chaining-register update for ECB/CBC/PCBC.
module chain_xor_unit
  import aes_defs::*;
#(
  parameter int W = 128
) (
  input  logic [1:0]   i_mode,
  input  logic         i_enc,
  input  logic [W-1:0] i_blk,
  input  logic [W-1:0] i_aes,
  input  logic [W-1:0] i_chain,
  output logic [W-1:0] o_aes_in,
  output logic [W-1:0] o_out,
  output logic [W-1:0] o_chain_next
);

  logic w_chained;

  assign w_chained = (i_mode == MODE_CBC) || (i_mode == MODE_PCBC);
  assign o_aes_in  = (w_chained && i_enc)  ? (i_blk ^ i_chain) : i_blk;
  assign o_out     = (w_chained && !i_enc) ? (i_aes ^ i_chain) : i_aes;

  // PCBC decrypt chains on the plaintext just produced, hence the use of o_out.
  always_comb begin
    o_chain_next = i_chain;
    case (i_mode)
      MODE_CBC:  o_chain_next = i_enc ? i_aes : i_blk;
      MODE_PCBC: o_chain_next = i_enc ? (i_blk ^ i_aes) : (i_blk ^ o_out);
      default:   o_chain_next = i_chain;
    endcase
  end

endmodule

// File: rtl/blk_chain_seq.sv
// Block-chaining sequencer: owns the IV/chaining register and walks one block at a time
// through the AES core with a start/done handshake, then a valid/ready result stream.
module blk_chain_seq #(
  parameter int BLK_S   = aes_defs::BLK_S,
  parameter int IV_BITS = aes_defs::IV_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               encryption,
  input  logic               decryption,
  input  logic               iv_load,
  input  logic [IV_BITS-1:0] iv_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLK_S-1:0]   in_blk,
  input  logic               in_last,
  output logic               aes_start,
  output logic [BLK_S-1:0]   aes_in_blk,
  input  logic               aes_done,
  input  logic [BLK_S-1:0]   aes_out_blk,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLK_S-1:0]   out_blk,
  output logic               out_last,
  output logic               err
);

  import aes_defs::*;

  state_e               r_state;
  state_e               w_state_next;
  logic [IV_BITS-1:0]   r_chain;
  logic                 r_iv_valid;
  logic                 r_err;
  logic [BLK_S-1:0]     r_blk;
  logic                 r_last;
  logic [1:0]           r_mode;
  logic                 r_enc;
  logic [BLK_S-1:0]     r_out_blk;
  logic                 r_out_last;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_legal;
  logic                 w_iv_take;
  logic                 w_done_take;
  logic                 w_out_hs;
  logic [BLK_S-1:0]     w_aes_in;
  logic [BLK_S-1:0]     w_out;
  logic [IV_BITS-1:0]   w_chain_next;

  // Gated by reset so every output reads 0 while reset is held, even in ECB with IDLE.
  assign w_in_ready  = (r_state == ST_IDLE) && !iv_load && (r_iv_valid || (mode == MODE_ECB))
                       && !r_err && reset;
  assign w_accept    = in_valid && w_in_ready;
  assign w_legal     = req_legal(mode, encryption, decryption);
  assign w_iv_take   = (r_state == ST_IDLE) && iv_load;
  assign w_done_take = (r_state == ST_WAIT) && aes_done;
  assign w_out_hs    = (r_state == ST_OUTPUT) && out_ready;

  chain_xor_unit #(
    .W (BLK_S)
  ) u_xor (
    .i_mode       (r_mode),
    .i_enc        (r_enc),
    .i_blk        (r_blk),
    .i_aes        (aes_out_blk),
    .i_chain      (r_chain),
    .o_aes_in     (w_aes_in),
    .o_out        (w_out),
    .o_chain_next (w_chain_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // aes_done only counts in WAIT, which begins the cycle after the aes_start pulse.
  always_comb begin
    w_state_next = r_state;
    aes_start    = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_legal) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        aes_start    = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (aes_done) begin
          w_state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Latched request: mode and direction are frozen here until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blk  <= '0;
      r_last <= 1'b0;
      r_mode <= MODE_ECB;
      r_enc  <= 1'b0;
    end else if (w_accept && w_legal) begin
      r_blk  <= in_blk;
      r_last <= in_last;
      r_mode <= mode;
      r_enc  <= encryption;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chain    <= '0;
      r_iv_valid <= 1'b0;
    end else begin
      if (w_iv_take) begin
        r_chain    <= iv_in;
        r_iv_valid <= 1'b1;
      end else if (w_done_take) begin
        r_chain <= w_chain_next;
      end
      if (w_out_hs && r_out_last) begin
        r_iv_valid <= 1'b0;
      end
    end
  end

  // iv_load has priority: it is the only way to leave the error state short of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_iv_take) begin
      r_err <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_blk  <= '0;
      r_out_last <= 1'b0;
    end else if (w_done_take) begin
      r_out_blk  <= w_out;
      r_out_last <= r_last;
    end
  end

  assign in_ready   = w_in_ready;
  assign aes_in_blk = w_aes_in;
  assign out_blk    = r_out_blk;
  assign out_last   = r_out_last;
  assign err        = r_err;

endmodule
